// File: rtl/gear_pkg.sv
// Shared types and GeAr(N,R,P) arithmetic helpers for the error-detect/correct controller.
package gear_pkg;

  localparam int unsigned MAX_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    CORRECT,
    DONE
  } state_t;

  function automatic int unsigned gear_k(input int unsigned n, r, p);
    return (n - r - p) / r + 1;
  endfunction

  // Result bits owned by sub-adder j (plus the carry-out bit for the last one)
  function automatic logic [MAX_W:0] seg_mask(input int unsigned n, r, p, j);
    logic [MAX_W:0] m;
    int unsigned    kk;
    m  = '0;
    kk = gear_k(n, r, p);
    for (int unsigned i = 0; i <= MAX_W; i++) begin
      if (j == 0 && i < r + p) m[i] = 1'b1;
      if (j != 0 && i >= j * r + p && i < j * r + r + p) m[i] = 1'b1;
      if (j == kk - 1 && i == n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic logic [MAX_W:0] gear_approx(input logic [MAX_W-1:0] a, b,
                                                 input int unsigned n, r, p);
    logic [MAX_W:0] acc;
    logic [MAX_W:0] sub;
    logic [MAX_W:0] wmask;
    logic [MAX_W:0] m;
    int unsigned    kk;
    acc   = '0;
    kk    = gear_k(n, r, p);
    wmask = (MAX_W+1)'((64'd1 << (r + p)) - 64'd1);
    for (int unsigned k = 0; k < MAX_W; k++) begin
      if (k < kk) begin
        sub = (((MAX_W+1)'(a) >> (k * r)) & wmask) + (((MAX_W+1)'(b) >> (k * r)) & wmask);
        m   = seg_mask(n, r, p, k);
        acc = (acc & ~m) | ((sub << (k * r)) & m);
      end
    end
    return acc;
  endfunction

  // Sub-adder k mispredicts when a real carry enters and ripples through all P prediction bits
  function automatic logic [MAX_W-1:0] gear_err(input logic [MAX_W-1:0] a, b,
                                                input int unsigned n, r, p);
    logic [MAX_W:0]   sum;
    logic [MAX_W-1:0] c;
    logic [MAX_W-1:0] pr;
    logic [MAX_W-1:0] e;
    logic             all_p;
    int unsigned      kk;
    sum = (MAX_W+1)'(a) + (MAX_W+1)'(b);
    c   = sum[MAX_W-1:0] ^ a ^ b;
    pr  = a ^ b;
    e   = '0;
    kk  = gear_k(n, r, p);
    for (int unsigned k = 1; k < MAX_W; k++) begin
      if (k < kk) begin
        all_p = 1'b1;
        for (int unsigned i = 0; i < MAX_W; i++) begin
          if (i < p) all_p = all_p & pr[k * r + i];
        end
        e[k] = c[k * r] & all_p;
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/gear_edc_ctrl_lowest_one.sv
// Priority encoder: index and one-hot of the lowest set bit of vec.
module gear_lowest_one #(
  parameter  int unsigned W  = 6,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx_c,
  output logic [W-1:0]  onehot_c
);

  // Scan high to low so the lowest set bit is the last one written
  always_comb begin
    idx_c    = '0;
    onehot_c = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx_c    = IW'(i);
        onehot_c = W'(1) << i;
      end
    end
  end

endmodule

// File: rtl/gear_edc_ctrl.sv
// GeAr approximate adder sequencer with per-sub-adder error detection and serial correction.
// Define GEAR_EDC_STATS_EN to add saturating operation/error/correction counters.
module gear_edc_ctrl
  import gear_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned R  = 1,
  parameter  int unsigned P  = 2,
  localparam int unsigned K  = gear_k(N, R, P),
  localparam int unsigned CW = $clog2(K)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in1,
  input  logic [N-1:0]  in2,
  input  logic          approx_mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N:0]    res,
  output logic          err_detected,
  output logic [CW-1:0] corr_cycles
`ifdef GEAR_EDC_STATS_EN
  ,
  output logic [15:0]   stat_ops,
  output logic [15:0]   stat_errs,
  output logic [15:0]   stat_corr
`endif
);

  state_t         state_q, state_d;
  logic [N-1:0]   a_q, b_q;
  logic           mode_q;
  logic [K-1:0]   err_q;
  logic [CW-1:0]  low_idx;
  logic [K-1:0]   low_oh;
  logic [N:0]     approx_c, exact_c, mask_c;
  logic [K-1:0]   err_c;

  assign approx_c = (N+1)'(gear_approx(MAX_W'(a_q), MAX_W'(b_q), N, R, P));
  assign exact_c  = (N+1)'(a_q) + (N+1)'(b_q);
  assign err_c    = K'(gear_err(MAX_W'(a_q), MAX_W'(b_q), N, R, P));
  assign mask_c   = (N+1)'(seg_mask(N, R, P, 32'(low_idx)));

  gear_lowest_one #(.W(K)) u_lowest (
    .vec      (err_q),
    .idx_c    (low_idx),
    .onehot_c (low_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid && in_ready) state_d = EVAL;
      EVAL:    state_d = (mode_q || err_c == '0) ? DONE : CORRECT;
      CORRECT: if ((err_q & ~low_oh) == '0) state_d = DONE;
      DONE:    if (out_valid && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags follow the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      mode_q       <= 1'b0;
      err_q        <= '0;
      res          <= '0;
      err_detected <= 1'b0;
      corr_cycles  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q    <= in1;
            b_q    <= in2;
            mode_q <= approx_mode;
          end
        end
        EVAL: begin
          res          <= approx_c;
          err_q        <= err_c;
          err_detected <= |err_c;
          corr_cycles  <= '0;
        end
        CORRECT: begin
          res         <= (res & ~mask_c) | (exact_c & mask_c);
          err_q       <= err_q & ~low_oh;
          corr_cycles <= corr_cycles + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef GEAR_EDC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops  <= '0;
      stat_errs <= '0;
      stat_corr <= '0;
    end else if (out_valid && out_ready) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (err_detected && stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
      if (corr_cycles != '0 && stat_corr != 16'hFFFF) stat_corr <= stat_corr + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gear_edc_ctrl.sv
// Directed bench for gear_edc_ctrl at N=8, R=1, P=2 (K=6); stats checks when GEAR_EDC_STATS_EN is set.
module tb_gear_edc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in1, in2;
  logic       approx_mode;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] res;
  logic       err_detected;
  logic [2:0] corr_cycles;
`ifdef GEAR_EDC_STATS_EN
  logic [15:0] stat_ops, stat_errs, stat_corr;
  int exp_ops = 0, exp_errs = 0, exp_corr = 0;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gear_edc_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in1          (in1),
    .in2          (in2),
    .approx_mode  (approx_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .res          (res),
    .err_detected (err_detected),
    .corr_cycles  (corr_cycles)
`ifdef GEAR_EDC_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_errs    (stat_errs),
    .stat_corr    (stat_corr)
`endif
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       mode;
    logic [8:0] res;
    logic       err;
    logic [2:0] cc;
    int         lat;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else passed++;
  endtask

  task automatic note_done(input logic e, input logic [2:0] c);
`ifdef GEAR_EDC_STATS_EN
    if (exp_ops < 16'hFFFF) exp_ops++;
    if (e) exp_errs++;
    if (c != 3'd0) exp_corr++;
`else
    if (e === 1'bx || c === 3'bxxx) $display("note: unknown completion flags");
`endif
  endtask

  // Present one operand pair and return at the first negedge after acceptance
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic m, input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in1 = a;
    in2 = b;
    approx_mode = m;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op(input logic e, input logic [2:0] c, input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    note_done(e, c);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    start_op(v.a, v.b, v.mode, tag);
    wait_done(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
    chk({tag, "_res"}, 32'(res), 32'(v.res));
    chk({tag, "_err"}, 32'(err_detected), 32'(v.err));
    chk({tag, "_cc"}, 32'(corr_cycles), 32'(v.cc));
    finish_op(v.err, v.cc, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0] = '{8'h03, 8'h01, 1'b0, 9'h004, 1'b0, 3'd0, 2};
    tbl[1] = '{8'h07, 8'h01, 1'b0, 9'h008, 1'b1, 3'd1, 3};
    tbl[2] = '{8'h07, 8'h01, 1'b1, 9'h000, 1'b1, 3'd0, 2};
    tbl[3] = '{8'hFF, 8'h01, 1'b0, 9'h100, 1'b1, 3'd5, 7};
    tbl[4] = '{8'hFF, 8'h01, 1'b1, 9'h0F8, 1'b1, 3'd0, 2};
    tbl[5] = '{8'h55, 8'hAA, 1'b0, 9'h0FF, 1'b0, 3'd0, 2};
    tbl[6] = '{8'h80, 8'h80, 1'b0, 9'h100, 1'b0, 3'd0, 2};
    tbl[7] = '{8'h1F, 8'h01, 1'b0, 9'h020, 1'b1, 3'd3, 5};
    tbl[8] = '{8'h1F, 8'h01, 1'b1, 9'h018, 1'b1, 3'd0, 2};

    rst = 1'b1;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    approx_mode = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", 32'(res), 32'd0);
    chk("rst_err", 32'(err_detected), 32'd0);
    chk("rst_cc", 32'(corr_cycles), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: result held while out_ready is low, busy-time in_valid ignored
    start_op(8'h07, 8'h01, 1'b0, "bp");
    wait_done(lat);
    chk("bp_lat", 32'(lat), 32'd3);
    for (int i = 0; i < 4; i++) begin
      in1 = 8'h03;
      in2 = 8'h01;
      in_valid = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("bp_res_%0d", i), 32'(res), 32'h008);
      chk($sformatf("bp_err_%0d", i), 32'(err_detected), 32'd1);
      chk($sformatf("bp_cc_%0d", i), 32'(corr_cycles), 32'd1);
      chk($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      chk($sformatf("bp_out_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    finish_op(1'b1, 3'd1, "bp");
    @(negedge clk);
    chk("bp_not_captured_ov", 32'(out_valid), 32'd0);
    chk("bp_not_captured_rdy", 32'(in_ready), 32'd1);
    run_vec(tbl[0], "bp_next");

    // Reset during the third CORRECT cycle aborts the operation
    start_op(8'hFF, 8'h01, 1'b0, "rstc");
    repeat (3) @(negedge clk);
    chk("rstc_mid_cc", 32'(corr_cycles), 32'd2);
    chk("rstc_mid_ov", 32'(out_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstc_in_ready", 32'(in_ready), 32'd1);
    chk("rstc_out_valid", 32'(out_valid), 32'd0);
    chk("rstc_res", 32'(res), 32'd0);
    chk("rstc_err", 32'(err_detected), 32'd0);
    chk("rstc_cc", 32'(corr_cycles), 32'd0);
`ifdef GEAR_EDC_STATS_EN
    exp_ops = 0;
    exp_errs = 0;
    exp_corr = 0;
    chk("rstc_stat_ops", 32'(stat_ops), 32'd0);
`endif
    repeat (2) @(negedge clk);
    chk("rstc_idle_ov", 32'(out_valid), 32'd0);
    run_vec(tbl[0], "post_rst");

`ifdef GEAR_EDC_STATS_EN
    for (int i = 1; i < 5; i++) run_vec(tbl[i], $sformatf("st%0d", i));
    chk("stat_ops", 32'(stat_ops), 32'(exp_ops));
    chk("stat_errs", 32'(stat_errs), 32'(exp_errs));
    chk("stat_corr", 32'(stat_corr), 32'(exp_corr));
    force dut.stat_ops = 16'hFFFF;
    @(negedge clk);
    release dut.stat_ops;
    exp_ops = 16'hFFFF;
    run_vec(tbl[3], "st_sat");
    chk("stat_ops_sat", 32'(stat_ops), 32'hFFFF);
    chk("stat_errs_final", 32'(stat_errs), 32'(exp_errs));
    chk("stat_corr_final", 32'(stat_corr), 32'(exp_corr));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
